// File: rtl/pipelined_decode_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipelined_decode_unit_if                                      |
// | Brief    : Fetch-side and execute-side handshake bundle of the decoder.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface pipelined_decode_unit_if #(
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [31:0]          instr_i;
  logic [31:0]          pc_i;
  logic                 flush_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [31:0]          out_pc_o;
  logic [31:0]          out_instr_o;
  logic                 reg_write_o;
  logic                 mem_write_o;
  logic                 branch_o;
  logic                 jump_o;
  logic                 is_jalr_o;
  logic                 is_lui_o;
  logic                 alu_src1_o;
  logic [1:0]           alu_src2_o;
  logic                 rd_source_o;
  logic [2:0]           format_o;
  logic [2:0]           mem_size_o;
  logic                 load_unsigned_o;
  logic [2:0]           cmp_op_o;
  logic [4:0]           alu_op_o;
  logic                 illegal_o;
  logic [ILL_CNT_W-1:0] ill_count_o;

  modport master (
    output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, reg_write_o, mem_write_o,
           branch_o, jump_o, is_jalr_o, is_lui_o, alu_src1_o, alu_src2_o, rd_source_o,
           format_o, mem_size_o, load_unsigned_o, cmp_op_o, alu_op_o, illegal_o, ill_count_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o, reg_write_o, mem_write_o,
           branch_o, jump_o, is_jalr_o, is_lui_o, alu_src1_o, alu_src2_o, rd_source_o,
           format_o, mem_size_o, load_unsigned_o, cmp_op_o, alu_op_o, illegal_o, ill_count_o
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_decode_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipelined_decode_unit                                         |
// | Brief    : Registered RV32I(+M) decoder with 2-entry skid buffer.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipelined_decode_unit #(
  parameter bit ENABLE_M  = 1'b0,
  parameter int ILL_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  pipelined_decode_unit_if.slave   bus
);

  localparam logic [6:0] c_OPC_LUI    = 7'h37;
  localparam logic [6:0] c_OPC_AUIPC  = 7'h17;
  localparam logic [6:0] c_OPC_JAL    = 7'h6F;
  localparam logic [6:0] c_OPC_JALR   = 7'h67;
  localparam logic [6:0] c_OPC_BRANCH = 7'h63;
  localparam logic [6:0] c_OPC_LOAD   = 7'h03;
  localparam logic [6:0] c_OPC_STORE  = 7'h23;
  localparam logic [6:0] c_OPC_OPIMM  = 7'h13;
  localparam logic [6:0] c_OPC_OP     = 7'h33;

  localparam logic [2:0] c_FMT_R = 3'd0;
  localparam logic [2:0] c_FMT_I = 3'd1;
  localparam logic [2:0] c_FMT_S = 3'd2;
  localparam logic [2:0] c_FMT_B = 3'd3;
  localparam logic [2:0] c_FMT_U = 3'd4;
  localparam logic [2:0] c_FMT_J = 3'd5;

  localparam logic [1:0] c_SRC2_RS2  = 2'd0;
  localparam logic [1:0] c_SRC2_IMM  = 2'd1;
  localparam logic [1:0] c_SRC2_FOUR = 2'd2;

  localparam logic [4:0] c_ALU_SUB = 5'd1;
  localparam logic [4:0] c_ALU_SRA = 5'd7;
  localparam logic [4:0] c_ALU_MUL = 5'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       is_jalr;
    logic       is_lui;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic       rd_source;
    logic [2:0] format;
    logic [2:0] mem_size;
    logic       load_unsigned;
    logic [2:0] cmp_op;
    logic [4:0] alu_op;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    dec_t        dec;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // funct3 -> ALU op for the shared OP / OP-IMM encodings (funct7 = 0)
  function automatic logic [4:0] f_alu_base(input logic [2:0] f3);
    case (f3)
      3'd0:    f_alu_base = 5'd0;
      3'd1:    f_alu_base = 5'd2;
      3'd2:    f_alu_base = 5'd3;
      3'd3:    f_alu_base = 5'd4;
      3'd4:    f_alu_base = 5'd5;
      3'd5:    f_alu_base = 5'd6;
      3'd6:    f_alu_base = 5'd8;
      default: f_alu_base = 5'd9;
    endcase
  endfunction

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic                 w_legal;
  dec_t                 w_dec;
  entry_t               w_new;
  logic                 w_accept;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  entry_t               r_main;
  entry_t               r_skid;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  assign w_opcode = bus.instr_i[6:0];
  assign w_funct3 = bus.instr_i[14:12];
  assign w_funct7 = bus.instr_i[31:25];

  always_comb begin
    w_dec   = '0;
    w_legal = 1'b0;
    case (w_opcode)
      c_OPC_LUI: begin
        w_legal          = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.is_lui     = 1'b1;
        w_dec.alu_src2   = c_SRC2_IMM;
        w_dec.format     = c_FMT_U;
      end
      c_OPC_AUIPC: begin
        w_legal          = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src1   = 1'b1;
        w_dec.alu_src2   = c_SRC2_IMM;
        w_dec.format     = c_FMT_U;
      end
      c_OPC_JAL: begin
        w_legal          = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.alu_src1   = 1'b1;
        w_dec.alu_src2   = c_SRC2_FOUR;
        w_dec.format     = c_FMT_J;
      end
      c_OPC_JALR: begin
        w_legal          = (w_funct3 == 3'd0);
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.is_jalr    = 1'b1;
        w_dec.alu_src2   = c_SRC2_FOUR;
        w_dec.format     = c_FMT_I;
      end
      c_OPC_BRANCH: begin
        w_legal          = 1'b1;
        w_dec.branch     = 1'b1;
        w_dec.format     = c_FMT_B;
        case (w_funct3)
          3'd0:    w_dec.cmp_op = 3'd0;
          3'd1:    w_dec.cmp_op = 3'd1;
          3'd4:    w_dec.cmp_op = 3'd2;
          3'd5:    w_dec.cmp_op = 3'd3;
          3'd6:    w_dec.cmp_op = 3'd4;
          3'd7:    w_dec.cmp_op = 3'd5;
          default: w_legal      = 1'b0;
        endcase
      end
      c_OPC_LOAD: begin
        w_legal             = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
        w_dec.reg_write     = 1'b1;
        w_dec.rd_source     = 1'b1;
        w_dec.alu_src2      = c_SRC2_IMM;
        w_dec.format        = c_FMT_I;
        w_dec.mem_size      = {1'b0, w_funct3[1:0]};
        w_dec.load_unsigned = w_funct3[2];
      end
      c_OPC_STORE: begin
        w_legal          = (w_funct3[2] == 1'b0) && (w_funct3[1:0] != 2'd3);
        w_dec.mem_write  = 1'b1;
        w_dec.alu_src2   = c_SRC2_IMM;
        w_dec.format     = c_FMT_S;
        w_dec.mem_size   = w_funct3;
      end
      c_OPC_OPIMM: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src2   = c_SRC2_IMM;
        w_dec.format     = c_FMT_I;
        w_dec.alu_op     = f_alu_base(w_funct3);
        case (w_funct3)
          3'd1:    w_legal = (w_funct7 == 7'h00);
          3'd5: begin
            w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
            if (w_funct7 == 7'h20) w_dec.alu_op = c_ALU_SRA;
          end
          default: w_legal = 1'b1;
        endcase
      end
      c_OPC_OP: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src2   = c_SRC2_RS2;
        w_dec.format     = c_FMT_R;
        case (w_funct7)
          7'h00: begin
            w_legal      = 1'b1;
            w_dec.alu_op = f_alu_base(w_funct3);
          end
          7'h20: begin
            w_legal      = (w_funct3 == 3'd0) || (w_funct3 == 3'd5);
            w_dec.alu_op = (w_funct3 == 3'd0) ? c_ALU_SUB : c_ALU_SRA;
          end
          7'h01: begin
            w_legal      = ENABLE_M;
            w_dec.alu_op = c_ALU_MUL + {2'b00, w_funct3};
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal words carry no side effects downstream: every field back to default.
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign w_new    = '{pc: bus.pc_i, instr: bus.instr_i, dec: w_dec};
  assign w_accept = bus.in_valid_i & r_in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
      r_ill_cnt   <= '0;
    end else if (bus.flush_i) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept && w_dec.illegal && !(&r_ill_cnt)) begin
        r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
      end
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_new;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && bus.out_ready_i) begin
            r_main <= w_new;
          end else if (w_accept) begin
            // main is stalled and must stay stable; newcomer parks in the skid slot
            r_skid     <= w_new;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (bus.out_ready_i) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (bus.out_ready_i) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o      = r_in_ready;
  assign bus.out_valid_o     = r_out_valid;
  assign bus.out_pc_o        = r_main.pc;
  assign bus.out_instr_o     = r_main.instr;
  assign bus.reg_write_o     = r_main.dec.reg_write;
  assign bus.mem_write_o     = r_main.dec.mem_write;
  assign bus.branch_o        = r_main.dec.branch;
  assign bus.jump_o          = r_main.dec.jump;
  assign bus.is_jalr_o       = r_main.dec.is_jalr;
  assign bus.is_lui_o        = r_main.dec.is_lui;
  assign bus.alu_src1_o      = r_main.dec.alu_src1;
  assign bus.alu_src2_o      = r_main.dec.alu_src2;
  assign bus.rd_source_o     = r_main.dec.rd_source;
  assign bus.format_o        = r_main.dec.format;
  assign bus.mem_size_o      = r_main.dec.mem_size;
  assign bus.load_unsigned_o = r_main.dec.load_unsigned;
  assign bus.cmp_op_o        = r_main.dec.cmp_op;
  assign bus.alu_op_o        = r_main.dec.alu_op;
  assign bus.illegal_o       = r_main.dec.illegal;
  assign bus.ill_count_o     = r_ill_cnt;

endmodule
`default_nettype wire
